text_term_ctrl: RTL and testbench

Character-terminal controller between the keyboard path (`ps2_keyboard` → `lookup_table` ASCII) and the vmem character buffer that `vga_ctrl`/vmem render.
- Accepts one ASCII code at a time over a valid/ready handshake and writes it into the buffer.
- Maintains the cursor and performs backspace, newline, clear-screen and one-line scroll.
- Owns the buffer's write port and a 1-cycle-latency read port; it is the only writer.

---
 rtl/term_pkg.sv | 28 ++
 rtl/term_fill_engine.sv | 76 +++++++
 rtl/text_term_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_text_term_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/term_pkg.sv
// Shared constants, state encoding and buffer address helper for the text terminal controller.
package term_pkg;

  localparam int TERM_COL_W  = 7;
  localparam int TERM_ROW_W  = 5;
  localparam int TERM_ADDR_W = TERM_ROW_W + TERM_COL_W;

  localparam logic [7:0] ASC_BS      = 8'h08;
  localparam logic [7:0] ASC_LF      = 8'h0A;
  localparam logic [7:0] ASC_FF      = 8'h0C;
  localparam logic [7:0] ASC_CR      = 8'h0D;
  localparam logic [7:0] ASC_SP      = 8'h20;
  localparam logic [7:0] ASC_DEL_LIM = 8'h7E;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_SCROLL,
    ST_SCROLL_CLR,
    ST_CLEAR
  } state_t;

  function automatic logic [TERM_ADDR_W-1:0] mk_addr(input logic [TERM_ROW_W-1:0] row,
                                                     input logic [TERM_COL_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/term_fill_engine.sv
// Row-major address walker: either fills rows with spaces, or copies each row one row up
// using a read followed by a write one cycle later.
module term_fill_engine
  import term_pkg::*;
#(
  parameter int COLS = 70
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   copy,
  input  logic [TERM_ROW_W-1:0]  first_row,
  input  logic [TERM_ROW_W-1:0]  last_row,
  input  logic [7:0]             rd_data,
  output logic [TERM_ADDR_W-1:0] rd_addr,
  output logic                   wr_en,
  output logic [TERM_ADDR_W-1:0] wr_addr,
  output logic [7:0]             wr_data,
  output logic                   done
);

  localparam logic [TERM_COL_W-1:0] COL_LAST = TERM_COL_W'(COLS - 1);

  logic                   active_reg;
  logic                   copy_reg;
  logic                   pipe_reg;
  logic [TERM_ROW_W-1:0]  row_reg;
  logic [TERM_ROW_W-1:0]  last_row_reg;
  logic [TERM_COL_W-1:0]  col_reg;
  logic [TERM_ADDR_W-1:0] pipe_addr_reg;
  logic                   walk_end;

  assign walk_end = active_reg && (col_reg == COL_LAST) && (row_reg == last_row_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      active_reg    <= 1'b0;
      copy_reg      <= 1'b0;
      pipe_reg      <= 1'b0;
      row_reg       <= '0;
      last_row_reg  <= '0;
      col_reg       <= '0;
      pipe_addr_reg <= '0;
    end else if (start) begin
      active_reg   <= 1'b1;
      copy_reg     <= copy;
      pipe_reg     <= 1'b0;
      row_reg      <= first_row;
      last_row_reg <= last_row;
      col_reg      <= '0;
    end else begin
      // In copy mode the write trails the read by one cycle and lands one row higher.
      pipe_reg      <= active_reg && copy_reg;
      pipe_addr_reg <= mk_addr(row_reg - 5'd1, col_reg);
      if (active_reg) begin
        if (col_reg == COL_LAST) begin
          col_reg <= '0;
          if (row_reg == last_row_reg) begin
            active_reg <= 1'b0;
          end else begin
            row_reg <= row_reg + 5'd1;
          end
        end else begin
          col_reg <= col_reg + 7'd1;
        end
      end
    end
  end

  assign rd_addr = mk_addr(row_reg, col_reg);
  assign wr_en   = copy_reg ? pipe_reg : active_reg;
  assign wr_addr = copy_reg ? pipe_addr_reg : rd_addr;
  assign wr_data = copy_reg ? rd_data : ASC_SP;
  assign done    = copy_reg ? (pipe_reg && !active_reg) : walk_end;

endmodule

// File: rtl/text_term_ctrl.sv
// Character terminal controller: accepts ASCII codes, writes the character buffer and
// handles cursor motion, backspace, newline, clear-screen and one-line scroll.
module text_term_ctrl
  import term_pkg::*;
#(
  parameter int COLS   = 70,
  parameter int ROWS   = 30,
  parameter int COL_W  = TERM_COL_W,
  parameter int ADDR_W = TERM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  input  logic [7:0]        key_ascii,
  output logic              key_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [COL_W-1:0]  cursor_col,
  output logic [4:0]        cursor_row,
  output logic              busy
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [4:0]       ROW_LAST = 5'(ROWS - 1);

  state_t            state_reg;
  logic [4:0]        row_reg;
  logic [COL_W-1:0]  col_reg;
  logic              wr_en_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [7:0]        wr_data_reg;
  logic              scroll_pend_reg;

  logic              is_print;
  logic              is_newline;
  logic              eng_start;
  logic              eng_copy;
  logic [4:0]        eng_first_row;
  logic [4:0]        eng_last_row;
  logic              eng_wr_en;
  logic [ADDR_W-1:0] eng_wr_addr;
  logic [7:0]        eng_wr_data;
  logic [ADDR_W-1:0] eng_rd_addr;
  logic              eng_done;

  assign is_print   = (key_ascii >= ASC_SP) && (key_ascii <= ASC_DEL_LIM);
  assign is_newline = (key_ascii == ASC_LF) || (key_ascii == ASC_CR);

  // Engine launches are decided on the same edge as the state change that needs them.
  always_comb begin
    eng_start     = 1'b0;
    eng_copy      = 1'b0;
    eng_first_row = '0;
    eng_last_row  = ROW_LAST;
    case (state_reg)
      ST_IDLE: begin
        if (key_valid && (key_ascii == ASC_FF)) begin
          eng_start = 1'b1;
        end else if (key_valid && is_newline && (row_reg == ROW_LAST)) begin
          eng_start     = 1'b1;
          eng_copy      = 1'b1;
          eng_first_row = 5'd1;
        end
      end
      ST_WRITE: begin
        if (scroll_pend_reg) begin
          eng_start     = 1'b1;
          eng_copy      = 1'b1;
          eng_first_row = 5'd1;
        end
      end
      ST_SCROLL: begin
        if (eng_done) begin
          eng_start     = 1'b1;
          eng_first_row = ROW_LAST;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      row_reg         <= '0;
      col_reg         <= '0;
      wr_en_reg       <= 1'b0;
      wr_addr_reg     <= '0;
      wr_data_reg     <= '0;
      scroll_pend_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (key_valid) begin
            if (is_print) begin
              state_reg   <= ST_WRITE;
              wr_en_reg   <= 1'b1;
              wr_addr_reg <= mk_addr(row_reg, col_reg);
              wr_data_reg <= key_ascii;
              if (col_reg != COL_LAST) begin
                col_reg <= col_reg + 7'd1;
              end else if (row_reg != ROW_LAST) begin
                row_reg <= row_reg + 5'd1;
                col_reg <= '0;
              end else begin
                scroll_pend_reg <= 1'b1;
              end
            end else if (is_newline) begin
              col_reg <= '0;
              if (row_reg != ROW_LAST) begin
                row_reg   <= row_reg + 5'd1;
                state_reg <= ST_WRITE;
              end else begin
                state_reg <= ST_SCROLL;
              end
            end else if (key_ascii == ASC_BS) begin
              state_reg <= ST_WRITE;
              if (col_reg != '0) begin
                col_reg     <= col_reg - 7'd1;
                wr_en_reg   <= 1'b1;
                wr_addr_reg <= mk_addr(row_reg, col_reg - 7'd1);
                wr_data_reg <= ASC_SP;
              end else if (row_reg != '0) begin
                row_reg     <= row_reg - 5'd1;
                col_reg     <= COL_LAST;
                wr_en_reg   <= 1'b1;
                wr_addr_reg <= mk_addr(row_reg - 5'd1, COL_LAST);
                wr_data_reg <= ASC_SP;
              end
            end else if (key_ascii == ASC_FF) begin
              state_reg <= ST_CLEAR;
            end else begin
              state_reg <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          wr_en_reg       <= 1'b0;
          scroll_pend_reg <= 1'b0;
          state_reg       <= scroll_pend_reg ? ST_SCROLL : ST_IDLE;
        end
        ST_SCROLL: begin
          if (eng_done) state_reg <= ST_SCROLL_CLR;
        end
        ST_SCROLL_CLR: begin
          if (eng_done) begin
            state_reg <= ST_IDLE;
            row_reg   <= ROW_LAST;
            col_reg   <= '0;
          end
        end
        ST_CLEAR: begin
          if (eng_done) begin
            state_reg <= ST_IDLE;
            row_reg   <= '0;
            col_reg   <= '0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  term_fill_engine #(
    .COLS(COLS)
  ) u_fill (
    .clk      (clk),
    .rst      (rst),
    .start    (eng_start),
    .copy     (eng_copy),
    .first_row(eng_first_row),
    .last_row (eng_last_row),
    .rd_data  (rd_data),
    .rd_addr  (eng_rd_addr),
    .wr_en    (eng_wr_en),
    .wr_addr  (eng_wr_addr),
    .wr_data  (eng_wr_data),
    .done     (eng_done)
  );

  assign key_ready  = (state_reg == ST_IDLE) && !rst;
  assign busy       = (state_reg != ST_IDLE);
  assign wr_en      = wr_en_reg | eng_wr_en;
  assign wr_addr    = eng_wr_en ? eng_wr_addr : wr_addr_reg;
  assign wr_data    = eng_wr_en ? eng_wr_data : wr_data_reg;
  assign rd_addr    = eng_rd_addr;
  assign cursor_col = col_reg;
  assign cursor_row = row_reg;

endmodule

// File: tb/tb_text_term_ctrl.sv
// Bench for text_term_ctrl: buffer memory model, screen-level reference model, vector table,
// scroll/clear corner sequences and randomized key streams.
module tb_text_term_ctrl;

  localparam int COLS = 70;
  localparam int ROWS = 30;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [7:0]  key_ascii = 8'h00;
  logic        key_ready;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [11:0] rd_addr;
  logic [7:0]  rd_data;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  always #5 clk = ~clk;

  text_term_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_ascii (key_ascii),
    .key_ready (key_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .cursor_col(cursor_col),
    .cursor_row(cursor_row),
    .busy      (busy)
  );

  // Character buffer with registered read; the bench can bulk-load a pattern while idle.
  logic [7:0] mem [4096];
  int         wr_count = 0;
  logic       fill_req = 1'b0;
  int         fill_kind = 0;

  function automatic logic [7:0] init_val(input int a);
    return 8'((a * 7 + 3) % 256);
  endfunction

  function automatic logic [7:0] pattern_val(input int kind, input int a);
    int r;
    int c;
    r = a / 128;
    c = a % 128;
    if (r < ROWS && c < COLS) begin
      if (kind == 1) return 8'(r + 48);
      if (kind == 2) return 8'hA5;
    end
    return init_val(a);
  endfunction

  always @(posedge clk) begin
    if (fill_req) begin
      for (int a = 0; a < 4096; a++) mem[a] <= pattern_val(fill_kind, a);
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
      wr_count     <= wr_count + 1;
    end
    rd_data <= mem[rd_addr];
  end

  // Reference model: visible screen as a 2-D array plus cursor.
  logic [7:0]  scr [ROWS][COLS];
  int          cur_r = 0;
  int          cur_c = 0;
  int          checks = 0;
  int          errors = 0;
  logic        last_wr;
  logic [11:0] last_addr;
  logic [7:0]  last_data;

  typedef struct {
    int          row;
    int          col;
    logic [7:0]  key;
    logic        exp_wr;
    logic [11:0] exp_addr;
    logic [7:0]  exp_data;
    int          exp_row;
    int          exp_col;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_pattern(input int kind);
    @(negedge clk);
    fill_kind = kind;
    fill_req  = 1'b1;
    @(negedge clk);
    fill_req = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = pattern_val(kind, r * 128 + c);
  endtask

  task automatic check_mem(input string name);
    int         bad_a;
    logic [7:0] ev;
    logic [7:0] bad_act;
    logic [7:0] bad_exp;
    bad_a   = -1;
    bad_act = 8'h00;
    bad_exp = 8'h00;
    for (int a = 0; a < 4096; a++) begin
      if ((a / 128) < ROWS && (a % 128) < COLS) ev = scr[a / 128][a % 128];
      else ev = init_val(a);
      if (mem[a] !== ev && bad_a < 0) begin
        bad_a   = a;
        bad_act = mem[a];
        bad_exp = ev;
      end
    end
    checks++;
    if (bad_a >= 0) begin
      errors++;
      $display("FAIL %s: addr %03h holds %02h expected %02h", name, bad_a, bad_act, bad_exp);
    end
  endtask

  task automatic model_scroll();
    for (int r = 0; r < ROWS - 1; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = scr[r + 1][c];
    for (int c = 0; c < COLS; c++) scr[ROWS - 1][c] = 8'h20;
  endtask

  // Expected first-cycle write, total busy cycles and new screen/cursor for one key.
  task automatic model_key(input logic [7:0] k, output logic ew, output int ea,
                           output int ed, output int eb);
    ew = 1'b0; ea = 0; ed = 0; eb = 1;
    if (k >= 8'h20 && k <= 8'h7E) begin
      ew = 1'b1; ea = cur_r * 128 + cur_c; ed = int'(k);
      scr[cur_r][cur_c] = k;
      if (cur_c < COLS - 1) cur_c++;
      else if (cur_r < ROWS - 1) begin cur_r++; cur_c = 0; end
      else begin model_scroll(); cur_c = 0; eb = 1 + (ROWS - 1) * COLS + 1 + COLS; end
    end else if (k == 8'h0A || k == 8'h0D) begin
      cur_c = 0;
      if (cur_r < ROWS - 1) cur_r++;
      else begin model_scroll(); eb = (ROWS - 1) * COLS + 1 + COLS; end
    end else if (k == 8'h08) begin
      if (cur_c > 0) begin
        cur_c--;
        scr[cur_r][cur_c] = 8'h20;
        ew = 1'b1; ea = cur_r * 128 + cur_c; ed = 32;
      end else if (cur_r > 0) begin
        cur_r--; cur_c = COLS - 1;
        scr[cur_r][cur_c] = 8'h20;
        ew = 1'b1; ea = cur_r * 128 + cur_c; ed = 32;
      end
    end else if (k == 8'h0C) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) scr[r][c] = 8'h20;
      cur_r = 0; cur_c = 0;
      ew = 1'b1; ea = 0; ed = 32; eb = ROWS * COLS;
    end
  endtask

  task automatic send_key(input logic [7:0] k);
    logic ew;
    int   ea, ed, eb, nb;
    bit   rdy_bad, addr_bad;
    model_key(k, ew, ea, ed, eb);
    @(negedge clk);
    chk("ready_before_key", key_ready, 1);
    key_valid = 1'b1;
    key_ascii = k;
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    key_ascii = 8'($urandom);
    last_wr   = wr_en;
    last_addr = wr_addr;
    last_data = wr_data;
    chk("first_wr_en", wr_en, ew);
    if (ew) begin
      chk("first_wr_addr", wr_addr, ea);
      chk("first_wr_data", wr_data, ed);
    end
    chk("ready_drop", key_ready, 0);
    nb = 0; rdy_bad = 0; addr_bad = 0;
    while (busy === 1'b1 && nb < 5000) begin
      nb++;
      if (key_ready !== 1'b0) rdy_bad = 1;
      if (wr_en === 1'b1 && wr_addr[6:0] >= 7'(COLS)) addr_bad = 1;
      @(negedge clk);
    end
    chk("busy_cycles", nb, eb);
    chk("ready_low_while_busy", rdy_bad, 0);
    chk("wr_col_in_range", addr_bad, 0);
    chk("idle_no_wr", wr_en, 0);
    chk("idle_ready", key_ready, 1);
    chk("cursor_row", cursor_row, cur_r);
    chk("cursor_col", cursor_col, cur_c);
    check_mem("buffer");
    $display("key %02h -> cursor (%0d,%0d) busy %0d", k, cursor_row, cursor_col, nb);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", key_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_row", cursor_row, 0);
    chk("rst_col", cursor_col, 0);
    rst = 1'b0;
    cur_r = 0;
    cur_c = 0;
    @(negedge clk);
    chk("ready_after_rst", key_ready, 1);
  endtask

  task automatic goto_pos(input int r, input int c, input logic [7:0] fill_ch);
    if (cur_r == r && cur_c == c) return;
    do_reset();
    for (int i = 0; i < r; i++) send_key(8'h0A);
    for (int i = 0; i < c; i++) send_key(fill_ch);
  endtask

  initial begin
    logic [7:0] oth [7];
    logic [7:0] k;
    int         nw, w0, p;
    bit         ok0, ok28, ok29, toolong, late_wr;

    oth = '{8'h00, 8'h07, 8'h09, 8'h1B, 8'h7F, 8'h80, 8'hFF};

    vecs[0]  = '{0,  0,  8'h48, 1'b1, 12'h000, 8'h48, 0,  1};
    vecs[1]  = '{0,  1,  8'h69, 1'b1, 12'h001, 8'h69, 0,  2};
    vecs[2]  = '{0,  69, 8'h41, 1'b1, 12'h045, 8'h41, 1,  0};
    vecs[3]  = '{2,  0,  8'h08, 1'b1, 12'h0C5, 8'h20, 1,  69};
    vecs[4]  = '{0,  0,  8'h08, 1'b0, 12'h000, 8'h00, 0,  0};
    vecs[5]  = '{0,  5,  8'h08, 1'b1, 12'h004, 8'h20, 0,  4};
    vecs[6]  = '{3,  10, 8'h0A, 1'b0, 12'h000, 8'h00, 4,  0};
    vecs[7]  = '{3,  10, 8'h0D, 1'b0, 12'h000, 8'h00, 4,  0};
    vecs[8]  = '{5,  5,  8'h07, 1'b0, 12'h000, 8'h00, 5,  5};
    vecs[9]  = '{5,  5,  8'h7F, 1'b0, 12'h000, 8'h00, 5,  5};
    vecs[10] = '{5,  5,  8'h7E, 1'b1, 12'h285, 8'h7E, 5,  6};
    vecs[11] = '{5,  6,  8'h20, 1'b1, 12'h286, 8'h20, 5,  7};
    vecs[12] = '{28, 69, 8'h7A, 1'b1, 12'hE45, 8'h7A, 29, 0};
    vecs[13] = '{29, 68, 8'h71, 1'b1, 12'hEC4, 8'h71, 29, 69};
    vecs[14] = '{29, 69, 8'h77, 1'b1, 12'hEC5, 8'h77, 29, 0};
    vecs[15] = '{0,  0,  8'h0C, 1'b1, 12'h000, 8'h20, 0,  0};

    load_pattern(0);
    do_reset();
    check_mem("buffer_after_reset");

    for (int i = 0; i < 16; i++) begin
      goto_pos(vecs[i].row, vecs[i].col, 8'h2E);
      send_key(vecs[i].key);
      chk("vec_wr_en", last_wr, vecs[i].exp_wr);
      if (vecs[i].exp_wr) begin
        chk("vec_wr_addr", last_addr, vecs[i].exp_addr);
        chk("vec_wr_data", last_data, vecs[i].exp_data);
      end
      chk("vec_row", cursor_row, vecs[i].exp_row);
      chk("vec_col", cursor_col, vecs[i].exp_col);
    end

    // Newline on the last row: full scroll of a row-numbered screen.
    load_pattern(1);
    goto_pos(29, 5, 8'h4D);
    send_key(8'h0D);
    ok0 = 1; ok28 = 1; ok29 = 1;
    for (int c = 0; c < COLS; c++) begin
      if (mem[c] !== 8'h31) ok0 = 0;
      if (mem[28 * 128 + c] !== 8'h4D) ok28 = 0;
      if (mem[29 * 128 + c] !== 8'h20) ok29 = 0;
    end
    chk("scroll_row0", ok0, 1);
    chk("scroll_row28", ok28, 1);
    chk("scroll_row29", ok29, 1);
    chk("scroll_cursor_row", cursor_row, 29);
    chk("scroll_cursor_col", cursor_col, 0);

    // Clear screen aborted by reset after exactly 1000 writes.
    load_pattern(2);
    do_reset();
    @(negedge clk);
    chk("clr_ready", key_ready, 1);
    key_valid = 1'b1;
    key_ascii = 8'h0C;
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    w0 = wr_count;
    nw = 0;
    toolong = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (wr_en === 1'b1) nw++;
      if (nw == 1000) break;
      @(negedge clk);
    end
    if (nw != 1000) toolong = 1;
    chk("clear_reached_1000", toolong, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_wr_en", wr_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready_in_rst", key_ready, 0);
    chk("abort_row", cursor_row, 0);
    chk("abort_col", cursor_col, 0);
    chk("abort_wr_addr", wr_addr, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", key_ready, 1);
    late_wr = 0;
    for (int i = 0; i < 20; i++) begin
      if (wr_en !== 1'b0) late_wr = 1;
      @(negedge clk);
    end
    chk("abort_no_late_writes", late_wr, 0);
    chk("abort_write_count", wr_count - w0, 1000);
    for (int i = 0; i < 1000; i++) scr[i / COLS][i % COLS] = 8'h20;
    cur_r = 0;
    cur_c = 0;
    chk("abort_entry_999", mem[14 * 128 + 19], 8'h20);
    chk("abort_entry_1000", mem[14 * 128 + 20], 8'hA5);
    check_mem("buffer_after_abort");
    $display("clear aborted after %0d writes", wr_count - w0);

    // Randomized key stream against the screen model.
    for (int i = 0; i < 250; i++) begin
      p = $urandom_range(0, 99);
      if (p < 70) k = 8'($urandom_range(32, 126));
      else if (p < 80) k = 8'h08;
      else if (p < 89) k = p[0] ? 8'h0A : 8'h0D;
      else if (p < 90) k = 8'h0C;
      else k = oth[$urandom_range(0, 6)];
      send_key(k);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
